// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable RAM family: lane width, FSM encoding
// and the data-width helper.
package ram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } state_e;

    function automatic int unsigned data_width(input int unsigned num_bytes);
        return num_bytes * BYTE_W;
    endfunction

endpackage

// File: rtl/ram_byteena_core.sv
// Storage array: one write port with per-lane enables, one synchronous read port.
// Read returns pre-write contents when both ports hit the same address.
module ram_byteena_core
    import ram_pkg::*;
#(
    parameter int unsigned NUM_BYTES  = 2,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                we_i,
    input  logic [NUM_BYTES-1:0]                be_i,
    input  logic [ADDR_WIDTH-1:0]               waddr_i,
    input  logic [data_width(NUM_BYTES)-1:0]    wdata_i,
    input  logic                                re_i,
    input  logic [ADDR_WIDTH-1:0]               raddr_i,
    output logic [data_width(NUM_BYTES)-1:0]    rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam int unsigned DataW = data_width(NUM_BYTES);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_byteena_clr.sv
// Byte-enable RAM with separate read port, optional output register, same-address
// read-during-write forwarding and a clear engine that zeroes the array.
module ram_byteena_clr
    import ram_pkg::*;
#(
    parameter int unsigned NUM_BYTES  = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr,
    input  logic                                we,
    input  logic [NUM_BYTES-1:0]                byte_ena,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [data_width(NUM_BYTES)-1:0]    data_in,
    input  logic                                re,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic [data_width(NUM_BYTES)-1:0]    data_out,
    output logic                                rd_valid,
    output logic                                ready
);

    localparam int unsigned DataW = data_width(NUM_BYTES);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    clearing, rd_acc, wr_acc;

    logic                    core_we;
    logic [NUM_BYTES-1:0]    core_be;
    logic [ADDR_WIDTH-1:0]   core_waddr;
    logic [DataW-1:0]        core_wdata, core_rdata;

    logic                    rd_v1_q;
    logic [NUM_BYTES-1:0]    fwd_mask_q;
    logic [DataW-1:0]        fwd_data_q;
    logic [DataW-1:0]        rd_merged;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clearing  = 1'b0;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        unique case (state_q)
            StClear: begin
                clearing  = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == '1) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (clr) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end else begin
                    rd_acc = re;
                    wr_acc = we;
                end
            end
        endcase
        // Reset edge must not touch the array or start a read.
        if (rst) begin
            clearing = 1'b0;
            rd_acc   = 1'b0;
            wr_acc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign ready = (state_q == StReady);

    assign core_we    = clearing | wr_acc;
    assign core_be    = clearing ? '1 : byte_ena;
    assign core_waddr = clearing ? clr_cnt_q : wr_addr;
    assign core_wdata = clearing ? '0 : data_in;

    ram_byteena_core #(
        .NUM_BYTES  (NUM_BYTES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (core_we),
        .be_i    (core_be),
        .waddr_i (core_waddr),
        .wdata_i (core_wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_addr),
        .rdata_o (core_rdata)
    );

    // Lanes written in the same cycle as the read are patched in after the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1_q    <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            rd_v1_q <= rd_acc;
            if (rd_acc) begin
                fwd_mask_q <= (wr_acc && (wr_addr == rd_addr)) ? byte_ena : '0;
                fwd_data_q <= data_in;
            end
        end
    end

    always_comb begin
        rd_merged = core_rdata;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (fwd_mask_q[i]) begin
                rd_merged[i*BYTE_W +: BYTE_W] = fwd_data_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DataW-1:0] dout_q;
        logic             vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= rd_v1_q;
                if (rd_v1_q) begin
                    dout_q <= rd_merged;
                end
            end
        end

        assign data_out = dout_q;
        assign rd_valid = vld_q;
    end else begin : g_out_comb
        assign data_out = rd_merged;
        assign rd_valid = rd_v1_q;
    end

endmodule

// File: tb/tb_ram_byteena_clr.sv
// Directed plan plus randomized traffic for ram_byteena_clr, checked every cycle
// against an array-based reference model with a two-cycle read delay.
module tb_ram_byteena_clr;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, clr, we, re;
    logic [1:0]  be;
    logic [7:0]  wa, ra;
    logic [15:0] wd;
    logic [15:0] dout;
    logic        rd_valid, ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    int          clear_left = DEPTH;
    bit          p1_v = 0;
    logic [15:0] p1_d = '0;
    bit          m_ov = 0;
    logic [15:0] m_od = '0;
    bit          m_ready = 0;

    ram_byteena_clr #(
        .NUM_BYTES  (2),
        .ADDR_WIDTH (8),
        .OUT_REG    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .we       (we),
        .byte_ena (be),
        .wr_addr  (wa),
        .data_in  (wd),
        .re       (re),
        .rd_addr  (ra),
        .data_out (dout),
        .rd_valid (rd_valid),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic zero_mem();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // Effect of one rising edge, from the behavioural rules.
    task automatic model_step();
        logic [15:0] rdv;
        if (rst) begin
            clear_left = DEPTH;
            p1_v       = 0;
            m_ov       = 0;
            m_od       = '0;
            zero_mem();
        end else begin
            m_ov = p1_v;
            if (p1_v) m_od = p1_d;
            if (clear_left > 0) begin
                clear_left--;
                p1_v = 0;
            end else if (clr) begin
                clear_left = DEPTH;
                p1_v       = 0;
                zero_mem();
            end else begin
                p1_v = re;
                if (re) begin
                    rdv = m_mem[ra];
                    for (int l = 0; l < 2; l++)
                        if (we && be[l] && wa == ra) rdv[8*l +: 8] = wd[8*l +: 8];
                    p1_d = rdv;
                end
                if (we) begin
                    for (int l = 0; l < 2; l++)
                        if (be[l]) m_mem[wa][8*l +: 8] = wd[8*l +: 8];
                end
            end
        end
        m_ready = (clear_left == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("ready", {31'b0, ready}, {31'b0, m_ready});
        check_eq("rd_valid", {31'b0, rd_valid}, {31'b0, m_ov});
        check_eq("data_out", {16'b0, dout}, {16'b0, m_od});
    endtask

    task automatic idle();
        rst = 0; clr = 0; we = 0; re = 0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [1:0] b, input logic [15:0] d);
        idle(); we = 1; wa = a; be = b; wd = d;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [15:0] exp, input string tag);
        idle(); re = 1; ra = a;
        tick();
        idle();
        check_eq({tag, "_early_v"}, {31'b0, rd_valid}, 32'd0);
        tick();
        check_eq(tag, {16'b0, dout}, {16'b0, exp});
        check_eq({tag, "_v"}, {31'b0, rd_valid}, 32'd1);
    endtask

    task automatic wait_ready(input string tag, output int edges);
        edges = 0;
        while (!ready && edges < 400) begin
            tick();
            edges++;
        end
        check_eq({tag, "_timeout"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        zero_mem();
        idle(); be = '0; wa = '0; ra = '0; wd = '0;
        rst = 1;
        tick(); tick();
        check_eq("rst_ready", {31'b0, ready}, 32'd0);
        check_eq("rst_dout", {16'b0, dout}, 32'd0);
        idle();

        // 1: clear after reset takes exactly DEPTH edges
        repeat (DEPTH - 1) tick();
        check_eq("ready_edge255", {31'b0, ready}, 32'd0);
        tick();
        check_eq("ready_edge256", {31'b0, ready}, 32'd1);
        do_read(8'd7, 16'h0000, "rd7_zero");

        // 2: lane writes
        do_write(8'd1, 2'b01, 16'h12F8);
        do_read(8'd1, 16'h00F8, "lane0");
        do_write(8'd1, 2'b10, 16'hAB00);
        do_read(8'd1, 16'hABF8, "lane1");

        // 3: no enabled lanes
        do_write(8'd4, 2'b00, 16'hEA60);
        do_read(8'd4, 16'h0000, "be00");

        // 4: same-address read during write
        do_write(8'd3, 2'b11, 16'h7700);
        idle(); we = 1; be = 2'b01; wd = 16'h02CC; wa = 8'd3; re = 1; ra = 8'd3;
        tick();
        idle();
        tick();
        check_eq("rdw_merge", {16'b0, dout}, 32'h77CC);
        check_eq("rdw_merge_v", {31'b0, rd_valid}, 32'd1);

        // 5: clear request, write in clear window is dropped
        idle(); clr = 1;
        tick();
        idle(); we = 1; wa = 8'd1; be = 2'b11; wd = 16'h5555;
        tick();
        idle();
        wait_ready("clr_wait", edges);
        check_eq("clr_edges", edges + 1, 32'd256);
        do_read(8'd1, 16'h0000, "clr_rd1");

        // 6: reset aborts reads in flight
        do_write(8'd2, 2'b11, 16'hBEEF);
        idle(); re = 1; ra = 8'd1;
        tick();
        ra = 8'd2;
        tick();
        idle(); rst = 1;
        tick();
        check_eq("rst_abort_v", {31'b0, rd_valid}, 32'd0);
        check_eq("rst_abort_d", {16'b0, dout}, 32'd0);
        idle();
        wait_ready("rst_wait", edges);
        check_eq("rst_edges", edges, 32'd256);

        // Randomized traffic, narrow address range to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            idle();
            we  = 1'($urandom);
            re  = 1'($urandom);
            be  = 2'($urandom);
            wd  = 16'($urandom);
            wa  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            clr = ($urandom_range(0, 399) == 0);
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        idle();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_byteena_clr.md
Name: ram_byteena_clr

Overview:
Parametrised single-clock RAM with per-byte write enables. It is the successor to the fixed 16-bit/2-lane byte-enable RAM. It adds:
- a separate read port,
- a configurable read pipeline with a valid flag,
- same-address read-during-write forwarding,
- a hardware clear engine that zeroes the whole array after reset or on request.

It sits as the general-purpose scratch/buffer memory for datapath blocks.

Parameters:
NUM_BYTES, 2, number of byte lanes; DATA_WIDTH = NUM_BYTES*8
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
OUT_REG, 1, 0 = read latency 1 cycle, 1 = extra output register, read latency 2 cycles

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  request full-array clear (sampled only in READY)
we  in  1  write strobe
byte_ena  in  NUM_BYTES  per-lane write enable; bit i controls data_in[8i+7:8i]
wr_addr  in  ADDR_WIDTH  write address
data_in  in  DATA_WIDTH  write data
re  in  1  read strobe
rd_addr  in  ADDR_WIDTH  read address
data_out  out  DATA_WIDTH  read data
rd_valid  out  1  data_out holds the result of a read for this cycle
ready  out  1  1 = accepting reads/writes (state READY)

Behaviour:
- Reset is synchronous and active-high: on any edge with rst=1:
  - state <= CLEAR, clr_cnt <= 0;
  - ready, rd_valid and data_out <= 0;
  - the read pipeline is flushed.
  - rst has priority over everything and aborts any in-flight clear or read.
- FSM has two states: CLEAR and READY.
- CLEAR:
  - Each edge with rst=0 writes 0 to mem[clr_cnt], then increments clr_cnt.
  - The edge that writes address DEPTH-1 moves state to READY, so ready=1 after exactly DEPTH edges following rst release (256 for the defaults).
  - we, re and clr are ignored in CLEAR; rd_valid stays 0.
- READY -> CLEAR when clr=1 on an edge:
  - clr_cnt <= 0 and ready <= 0 on that edge.
  - we/re presented in the same cycle are ignored.
  - Reads already in the pipeline still complete and assert rd_valid.
- Write, in READY with we=1 and clr=0:
  - For each lane i with byte_ena[i]=1, mem[wr_addr] lane i <= data_in lane i.
  - Lanes with byte_ena[i]=0 are unchanged.
  - byte_ena all zero means no change to memory.
- Read, in READY with re=1 and clr=0:
  - rd_addr is captured at the edge.
  - OUT_REG=0: data_out and rd_valid update on that same edge (latency 1).
  - OUT_REG=1: they update one edge later (latency 2).
  - Back-to-back reads run at full throughput, one per cycle.
- Between reads, rd_valid=0 and data_out holds its last value.
- Read-during-write, same cycle with rd_addr == wr_addr: the read returns merged data.
  - Enabled lanes come from data_in; other lanes come from the old memory contents.
  - When addresses differ, the read returns old contents as stored.
- Addresses wrap naturally within ADDR_WIDTH; no out-of-range case exists.
- Width rule: DATA_WIDTH = NUM_BYTES*8 exactly; NUM_BYTES >= 1.

Decomposition:
- Shared package ram_pkg holds:
  - BYTE_W = 8;
  - the state encoding (CLEAR = 1'b0, READY = 1'b1);
  - a function computing DATA_WIDTH from NUM_BYTES.
- Sub-module ram_byteena_core holds the storage array:
  - one write port with per-lane enables;
  - one synchronous read port, with no forwarding.
- The top level holds the FSM, clear counter, forwarding mux, write-port mux (clear vs user) and output pipeline.

Test Plan (NUM_BYTES=2, ADDR_WIDTH=8, OUT_REG=1):
1. rst=1 for 2 cycles, then 0 -> ready=0 for 256 edges, ready=1 after the 256th. Then re with rd_addr=7 -> data_out=0x0000, rd_valid=1, 2 edges later.
2. Lane writes to wr_addr=1:
   - byte_ena=01, data_in=0x12F8, then read -> 0x00F8.
   - byte_ena=10, data_in=0xAB00, then read -> 0xABF8.
3. byte_ena=00, data_in=0xEA60, wr_addr=4, then read addr 4 -> 0x0000.
4. Same cycle: we, byte_ena=01, data_in=0x02CC, wr_addr=3, with re, rd_addr=3, and addr 3 previously holding 0x7700 -> data_out=0x77CC, rd_valid=1, 2 edges later.
5. After test 2, pulse clr for 1 cycle, with we at addr 1 in the clear window -> ready=0 for 256 edges. Then reading addr 1 -> 0x0000 (the write was ignored).
6. Issue reads at addrs 1 and 2 back-to-back, assert rst on the next edge -> rd_valid=0 and data_out=0x0000 after that edge, then the clear sequence restarts.
